// File: rtl/adder_arb_pkg.sv
// Shared definitions for the adder arbiter.
//   arb_state_t : FSM state encoding (IDLE, SETTLE, RESP)
//   ID_W        : requester id width for the default of 4 requesters
//   rr_pick     : round-robin search; first set bit of valid at or above ptr,
//                 wrapping modulo n (n must be a power of two, at most RR_MAX)
package adder_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  localparam int N_REQ_DEF = 4;
  localparam int ID_W      = $clog2(N_REQ_DEF);
  localparam int RR_MAX    = 32;

  // The loop covers the largest supported requester count; entries beyond n
  // are ignored. Wrapping uses a mask because n is a power of two.
  function automatic logic [4:0] rr_pick(input logic [RR_MAX-1:0] valid,
                                         input logic [4:0]        ptr,
                                         input int                n);
    logic [4:0] pick;
    logic [4:0] idx;
    logic       found;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < RR_MAX; i++) begin
      idx = (ptr + 5'(i)) & 5'(n - 1);
      if ((i < n) && !found && valid[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/add16.sv
// Structural 16-bit ripple-carry adder, carry-in tied to 0.
//   A, B : operands
//   Sum  : A+B modulo 2^16
//   CO   : carry out of bit 15
// The carry ripples through all sixteen cells, so the owner must hold the
// operands stable for several cycles before sampling Sum/CO.
module add16 (
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [15:0] Sum,
  output logic        CO
);

  logic [16:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < 16; i++) begin : g_fa
    // One full-adder cell per bit.
    assign Sum[i]     = A[i] ^ B[i] ^ carry[i];
    assign carry[i+1] = (A[i] & B[i]) | (A[i] & carry[i]) | (B[i] & carry[i]);
  end

  assign CO = carry[16];

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one ripple-carry adder between N_REQ clients.
//   Clk, Reset_n          : clock, asynchronous active-low reset
//   req_valid/req_ready   : per-requester operand handshake (ready one-hot or 0)
//   req_A, req_B          : operands per requester
//   resp_valid/resp_ready : result handshake
//   resp_id/resp_sum/resp_co : owner of result, A+B, carry out
//   busy                  : high whenever the FSM is not IDLE
// Handshake rule (both interfaces): a transfer happens on a rising edge where
// valid and ready are both high; the producer holds its payload until then.
// req_ready is only ever high in IDLE, combinationally, for the granted
// requester. resp_* are registered and stay stable while waiting in RESP.
// WIDTH must be 16 to match the shared add16 instance.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int N_REQ         = 4,
  parameter int WIDTH         = 16,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                          Clk,
  input  logic                          Reset_n,
  input  logic [N_REQ-1:0]              req_valid,
  output logic [N_REQ-1:0]              req_ready,
  input  logic [N_REQ-1:0][WIDTH-1:0]   req_A,
  input  logic [N_REQ-1:0][WIDTH-1:0]   req_B,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [$clog2(N_REQ)-1:0]      resp_id,
  output logic [WIDTH-1:0]              resp_sum,
  output logic                          resp_co,
  output logic                          busy
);

  localparam int IDW   = $clog2(N_REQ);
  localparam int CNT_W = $clog2(SETTLE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  arb_state_t       state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] settle_cnt_q, settle_cnt_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [IDW-1:0]   op_id_q, op_id_d;
  logic             resp_valid_q, resp_valid_d;
  logic [IDW-1:0]   resp_id_q, resp_id_d;
  logic [WIDTH-1:0] resp_sum_q, resp_sum_d;
  logic             resp_co_q, resp_co_d;

  logic [IDW-1:0]   grant_idx;
  logic             accept;
  logic [WIDTH-1:0] add_sum;
  logic             add_co;

  assign grant_idx = IDW'(rr_pick(RR_MAX'(req_valid), 5'(rr_ptr_q), N_REQ));
  // Reset_n gates accept so req_ready stays low while reset is held.
  assign accept    = (state_q == IDLE) && (|req_valid) && Reset_n;
  assign req_ready = accept ? (N_REQ'(1) << grant_idx) : '0;

  // Operand registers feed the adder directly; the settle window covers the
  // ripple path from op_*_q through the carry chain into resp_*_q.
  add16 u_add16 (
    .A   (op_a_q),
    .B   (op_b_q),
    .Sum (add_sum),
    .CO  (add_co)
  );

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    settle_cnt_d = settle_cnt_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_id_d      = op_id_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_sum_d   = resp_sum_q;
    resp_co_d    = resp_co_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_a_d       = req_A[grant_idx];
          op_b_d       = req_B[grant_idx];
          op_id_d      = grant_idx;
          settle_cnt_d = SETTLE_LOAD;
          state_d      = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt_q != '0) begin
          settle_cnt_d = settle_cnt_q - CNT_W'(1);
        end else begin
          resp_sum_d   = add_sum;
          resp_co_d    = add_co;
          resp_id_d    = op_id_q;
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          // N_REQ is a power of two, so the IDW-bit add wraps correctly.
          rr_ptr_d     = op_id_q + IDW'(1);
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      settle_cnt_q <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_id_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_sum_q   <= '0;
      resp_co_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      settle_cnt_q <= settle_cnt_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_id_q      <= op_id_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_sum_q   <= resp_sum_d;
      resp_co_q    <= resp_co_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_sum   = resp_sum_q;
  assign resp_co    = resp_co_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter (N_REQ=4, WIDTH=16, SETTLE_CYCLES=2).
module tb_adder_arbiter;

  localparam int N   = 4;
  localparam int W   = 16;
  localparam int SC  = 2;
  localparam int IDW = 2;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  logic Reset_n;
  always #5 Clk = ~Clk;

  logic [N-1:0]        req_valid;
  logic [N-1:0]        req_ready;
  logic [N-1:0][W-1:0] req_A;
  logic [N-1:0][W-1:0] req_B;
  logic                resp_valid;
  logic                resp_ready;
  logic [IDW-1:0]      resp_id;
  logic [W-1:0]        resp_sum;
  logic                resp_co;
  logic                busy;

  adder_arbiter #(.N_REQ(N), .WIDTH(W), .SETTLE_CYCLES(SC)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_A      (req_A),
    .req_B      (req_B),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_sum   (resp_sum),
    .resp_co    (resp_co),
    .busy       (busy)
  );

  // ---------------- scoreboard ----------------
  int vectors     = 0;
  int miscompares = 0;

  logic [IDW+W:0] exp_q[$];   // {id, carry, sum} of every accepted request
  int             gnt_log[$]; // observed grant order

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Transaction view: idle, or a result due m_left cycles after acceptance,
  // or a result waiting for the consumer. The sum is plain 17-bit arithmetic.
  bit           m_idle = 1'b1;
  bit           m_resp = 1'b0;
  int           m_left = 0;
  int           m_ptr  = 0;
  int           m_id   = 0;

  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  // Called at posedge+1 with inputs already driven; compares at the falling
  // edge, advances the model across the rising edge, returns at posedge+1.
  task automatic step();
    int          g;
    logic [N-1:0] e_ready;
    logic [W:0]  s17;
    @(negedge Clk);
    g       = m_idle ? pick(req_valid, m_ptr) : -1;
    e_ready = '0;
    if (g >= 0) e_ready[g] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(e_ready));
    check("busy", 32'(busy), 32'(!m_idle));
    check("resp_valid", 32'(resp_valid), 32'(m_resp));
    if (resp_valid) begin
      if (exp_q.size() == 0) check("resp_unexpected", 32'(1), 32'(0));
      else check("resp_data", 32'({resp_id, resp_co, resp_sum}), 32'(exp_q[0]));
    end
    for (int k = 0; k < N; k++) if (req_ready[k]) gnt_log.push_back(k);
    if (m_idle && g >= 0) begin
      s17 = {1'b0, req_A[g]} + {1'b0, req_B[g]};
      exp_q.push_back({IDW'(g), s17});
      m_id   = g;
      m_idle = 1'b0;
      m_left = SC;
    end else if (!m_idle && !m_resp) begin
      m_left--;
      if (m_left == 0) m_resp = 1'b1;
    end else if (m_resp && resp_ready) begin
      m_resp = 1'b0;
      m_idle = 1'b1;
      m_ptr  = (m_id + 1) % N;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    @(posedge Clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    Reset_n = 1'b0;
    #1;
    check("rst_resp_valid", 32'(resp_valid), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_resp_id", 32'(resp_id), 32'(0));
    check("rst_resp_sum", 32'(resp_sum), 32'(0));
    check("rst_resp_co", 32'(resp_co), 32'(0));
    check("rst_req_ready", 32'(req_ready), 32'(0));
    @(posedge Clk);
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    m_idle = 1'b1;
    m_resp = 1'b0;
    m_left = 0;
    m_ptr  = 0;
    exp_q.delete();
  endtask

  task automatic clear_inputs();
    req_valid = '0;
    for (int k = 0; k < N; k++) begin
      req_A[k] = '0;
      req_B[k] = '0;
    end
  endtask

  task automatic drain(input int cycles);
    req_valid  = '0;
    resp_ready = 1'b1;
    for (int i = 0; i < cycles; i++) step();
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    int          id;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] sum;
    logic        co;
  } vec_t;

  vec_t tbl[7];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [IDW+W:0] snap;
    logic [N-1:0]   gv;
    int             n3;
    int             exp_order[5];

    tbl[0] = '{2, 16'h1234, 16'h0F0F, 16'h2143, 1'b0};
    tbl[1] = '{1, 16'hFFFF, 16'h0001, 16'h0000, 1'b1};
    tbl[2] = '{0, 16'h8000, 16'h8000, 16'h0000, 1'b1};
    tbl[3] = '{3, 16'h0000, 16'h0000, 16'h0000, 1'b0};
    tbl[4] = '{2, 16'h7FFF, 16'h0001, 16'h8000, 1'b0};
    tbl[5] = '{1, 16'hABCD, 16'h5432, 16'hFFFF, 1'b0};
    tbl[6] = '{3, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1};

    Reset_n    = 1'b1;
    resp_ready = 1'b0;
    clear_inputs();
    #2;
    do_reset();

    // Single requests from the table: same-cycle ready, result at t+SC+1.
    foreach (tbl[i]) begin
      clear_inputs();
      resp_ready            = 1'b1;
      req_valid[tbl[i].id]  = 1'b1;
      req_A[tbl[i].id]      = tbl[i].a;
      req_B[tbl[i].id]      = tbl[i].b;
      #1;
      gv = '0;
      gv[tbl[i].id] = 1'b1;
      check("tbl_ready", 32'(req_ready), 32'(gv));
      step();
      req_valid = '0;
      for (int c = 0; c < SC; c++) begin
        check("tbl_early_valid", 32'(resp_valid), 32'(0));
        step();
      end
      check("tbl_latency_valid", 32'(resp_valid), 32'(1));
      check("tbl_sum", 32'(resp_sum), 32'(tbl[i].sum));
      check("tbl_co", 32'(resp_co), 32'(tbl[i].co));
      check("tbl_id", 32'(resp_id), 32'(tbl[i].id));
      step();
      step();
    end

    // Round-robin: everyone valid, grants must rotate 0,1,2,3,0.
    do_reset();
    for (int k = 0; k < N; k++) begin
      req_A[k] = 16'h1111 * W'(k + 1);
      req_B[k] = 16'h0F00 + W'(k);
    end
    req_valid  = '1;
    resp_ready = 1'b1;
    gnt_log.delete();
    for (int i = 0; i < 5 * (SC + 2); i++) step();
    exp_order = '{0, 1, 2, 3, 0};
    check("rr_count", 32'(gnt_log.size() >= 5), 32'(1));
    for (int i = 0; i < 5; i++) begin
      if (i < gnt_log.size()) check("rr_order", 32'(gnt_log[i]), 32'(exp_order[i]));
    end
    drain(SC + 3);

    // Back-pressure: hold the result 5 cycles, then next grant right after.
    req_valid  = '1;
    resp_ready = 1'b0;
    for (int i = 0; i < 10 && !resp_valid; i++) step();
    check("bp_valid_seen", 32'(resp_valid), 32'(1));
    snap = {resp_id, resp_co, resp_sum};
    for (int i = 0; i < 5; i++) step();
    check("bp_stable", 32'({resp_id, resp_co, resp_sum}), 32'(snap));
    resp_ready = 1'b1;
    step();
    #1;
    check("bp_next_grant", 32'(|req_ready), 32'(1));
    step();
    drain(SC + 3);

    // Reset during SETTLE: operation dropped, arbitration back at 0.
    clear_inputs();
    req_valid[2] = 1'b1;
    req_A[2]     = 16'h4444;
    req_B[2]     = 16'h1111;
    resp_ready   = 1'b1;
    step();
    req_valid = '0;
    step();
    req_valid = '1;
    do_reset();
    #1;
    check("mid_rst_grant0", 32'(req_ready), 32'(4'b0001));
    for (int i = 0; i < SC + 2; i++) step();
    drain(SC + 3);

    // Withdrawn request: 3 raised in SETTLE and dropped before IDLE.
    do_reset();
    clear_inputs();
    resp_ready   = 1'b1;
    req_valid[0] = 1'b1;
    req_A[0]     = 16'h0101;
    req_B[0]     = 16'h0202;
    gnt_log.delete();
    step();
    req_valid = 4'b1010;
    req_A[1]  = 16'h00FF;
    req_B[1]  = 16'hFF00;
    req_A[3]  = 16'h3333;
    req_B[3]  = 16'h3333;
    step();
    step();
    req_valid = 4'b0010;
    step();
    #1;
    check("wd_grant1", 32'(req_ready), 32'(4'b0010));
    for (int i = 0; i < SC + 2; i++) step();
    req_valid = '0;
    n3 = 0;
    foreach (gnt_log[i]) if (gnt_log[i] == 3) n3++;
    check("wd_never3", 32'(n3), 32'(0));
    drain(SC + 3);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      req_valid = N'($urandom_range(0, (1 << N) - 1));
      for (int k = 0; k < N; k++) begin
        req_A[k] = W'($urandom);
        req_B[k] = W'($urandom);
      end
      resp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain(SC + 4);
    check("final_queue_empty", 32'(exp_q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
